// File: rtl/rst_req_gen.sv
// rst_req_gen: source-side reset issuer. It drives RST_OUT into a destination
// domain and waits for that domain's released reset (RST_ACK) to come back.
// Ports:
//   CLK        system clock
//   RST        async active-low reset; power-on runs one full sequence
//   SW_RST_REQ one-cycle software request, accepted only in IDLE
//   RST_ACK    destination reset level (async), 0 = destination in reset
//   RST_OUT    registered active-low reset to the destination
//   BUSY       high while a sequence is in progress
//   DONE       one-cycle pulse on successful completion
//   ERR        sticky timeout flag, cleared by an accepted request
module rst_req_gen #(
  parameter int NUM_STAGES     = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_RST_REQ,
  input  logic RST_ACK,
  output logic RST_OUT,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_MAX =
    CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_STAGES-1:0] ack_ff;
  logic                  ack_s;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] hold_q;
  logic [CNT_WIDTH-1:0] hold_d;
  logic [CNT_WIDTH-1:0] to_q;
  logic [CNT_WIDTH-1:0] to_d;
  logic [CNT_WIDTH-1:0] hold_inc;
  logic [CNT_WIDTH-1:0] to_inc;
  logic                 hold_ok;
  logic                 to_exp;
  logic                 rst_out_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 err_d;

  // RST_ACK is asynchronous to CLK; only the last stage is used.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_ff <= '0;
    end else begin
      ack_ff <= {ack_ff[NUM_STAGES-2:0], RST_ACK};
    end
  end

  assign ack_s = ack_ff[NUM_STAGES-1];

  // Both counters saturate instead of wrapping.
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q
                                         : hold_q + 1'b1;
  assign to_inc   = (to_q == CNT_MAX) ? to_q
                                      : to_q + 1'b1;
  assign hold_ok  = (hold_q >= HOLD_LAST);
  assign to_exp   = (to_q >= TO_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ASSERT;
      hold_q  <= '0;
      to_q    <= '0;
      RST_OUT <= 1'b0;
      BUSY    <= 1'b1;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      RST_OUT <= rst_out_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      ERR     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    to_d      = to_q;
    rst_out_d = RST_OUT;
    busy_d    = BUSY;
    done_d    = 1'b0;
    err_d     = ERR;
    unique case (state_q)
      ASSERT: begin
        rst_out_d = 1'b0;
        hold_d    = hold_inc;
        to_d      = to_inc;
        // RST_OUT stays low on this edge and rises
        // one edge later, so the low time is the
        // full hold count.
        if (hold_ok && !ack_s) begin
          state_d = RELEASE;
          to_d    = '0;
        end else if (to_exp) begin
          // Destination never entered reset.
          state_d   = IDLE;
          rst_out_d = 1'b1;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end
      end
      RELEASE: begin
        rst_out_d = 1'b1;
        to_d      = to_inc;
        if (ack_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (to_exp) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      IDLE: begin
        rst_out_d = 1'b1;
        busy_d    = 1'b0;
        if (SW_RST_REQ) begin
          state_d = ASSERT;
          hold_d  = '0;
          to_d    = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d   = ASSERT;
        rst_out_d = 1'b0;
        busy_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_req_gen.sv
// tb_rst_req_gen: scoreboard bench for rst_req_gen.
// A destination model feeds RST_OUT back as RST_ACK with set delays.
module tb_rst_req_gen;

  localparam int NS   = 2;
  localparam int HOLD = 8;
  localparam int TO   = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic req   = 1'b0;
  logic ack   = 1'b1;
  logic rst_out;
  logic busy;
  logic done;
  logic err;

  rst_req_gen #(
    .NUM_STAGES    (NS),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (8)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .SW_RST_REQ(req),
    .RST_ACK   (ack),
    .RST_OUT   (rst_out),
    .BUSY      (busy),
    .DONE      (done),
    .ERR       (err)
  );

  always #5 clk = ~clk;

  // done/err at the end of a sequence, RST_OUT low
  // length, and cycles from RST_OUT rising to the end.
  typedef struct {
    int done;
    int err;
    int low;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_chk      = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int starts     = 0;
  int exp_starts = 0;
  int low_len    = 0;
  int rise_cyc   = 0;

  logic busy_p = 1'b1;
  logic out_p  = 1'b0;
  logic done_p = 1'b0;

  // 0: follow RST_OUT, fall after df, rise after dr
  // 1: stuck 0, 2: stuck 1
  int mode = 0;
  int df   = 2;
  int dr   = 2;
  logic [31:0] hist = '1;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic push_exp(input int d, input int r,
                          input int l, input int t);
    exp_t x;
    x.done = d;
    x.err  = r;
    x.low  = l;
    x.lat  = t;
    sb.push_back(x);
  endtask

  task automatic do_req(input int n);
    @(negedge clk);
    req = 1'b1;
    repeat (n) @(negedge clk);
    req = 1'b0;
    exp_starts++;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < max) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", busy, 0);
  endtask

  // destination domain model
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    hist = {hist[30:0], rst_out};
    case (mode)
      0:       ack = hist[df] | hist[dr];
      1:       ack = 1'b0;
      default: ack = 1'b1;
    endcase
  end

  // monitor: pops the scoreboard when a sequence ends
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      low_len = 0;
      busy_p  = 1'b1;
      out_p   = 1'b0;
      done_p  = 1'b0;
    end else begin
      if (busy && !busy_p) begin
        starts++;
        low_len = 0;
      end
      if (!rst_out) low_len++;
      if (rst_out && !out_p) rise_cyc = cyc;
      if (done_p) check("done_width", done, 0);
      if (!busy && busy_p) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          e = sb.pop_front();
          check("done", done, e.done);
          check("err", err, e.err);
          check("low_len", low_len, e.low);
          check("rise_to_end", cyc - rise_cyc, e.lat);
        end
      end
      busy_p = busy;
      out_p  = rst_out;
      done_p = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // power-on
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_in_reset", rst_out, 0);
    check("busy_in_reset", busy, 1);
    check("done_in_reset", done, 0);
    check("err_in_reset", err, 0);
    repeat (5) @(posedge clk);
    // low_len includes the negedge before the first
    // active edge after release, hence HOLD+1.
    push_exp(1, 0, HOLD + 1, 2 + NS + 1);
    #1 rst_n = 1'b1;
    wait_idle(200);
    check("po_rst_out_high", rst_out, 1);
    check("po_err", err, 0);

    // software reset, extra requests while busy;
    // the last one lands on the DONE edge
    df = 3;
    dr = 3;
    repeat (4) @(negedge clk);
    push_exp(1, 0, HOLD, 3 + NS + 1);
    do_req(1);
    repeat (3) begin
      repeat (4) @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    wait_idle(200);
    repeat (20) @(negedge clk);
    check("sw_starts", starts, exp_starts);
    check("sw_busy_idle", busy, 0);

    // two consecutive request cycles
    push_exp(1, 0, HOLD, 3 + NS + 1);
    do_req(2);
    wait_idle(200);
    repeat (10) @(negedge clk);
    check("consec_starts", starts, exp_starts);

    // slow ack entry
    df = 20;
    dr = 2;
    push_exp(1, 0, 20 + NS + 2, 2 + NS + 1);
    do_req(1);
    wait_idle(300);

    // release timeout
    mode = 1;
    push_exp(0, 1, HOLD, TO - 1);
    do_req(1);
    wait_idle(300);
    check("rto_rst_out", rst_out, 1);
    check("rto_busy", busy, 0);

    // assert timeout; the request clears ERR
    mode = 2;
    repeat (5) @(negedge clk);
    push_exp(0, 1, TO - 1, 0);
    do_req(1);
    check("req_clears_err", err, 0);
    check("req_sets_busy", busy, 1);
    wait_idle(300);
    check("ato_rst_out", rst_out, 1);

    // normal sequence after a timeout
    mode = 0;
    df = 3;
    dr = 3;
    repeat (5) @(negedge clk);
    push_exp(1, 0, HOLD, 3 + NS + 1);
    do_req(1);
    check("req_clears_err2", err, 0);
    wait_idle(200);

    // reset mid-sequence while in RELEASE
    mode = 1;
    do_req(1);
    repeat (15) @(negedge clk);
    check("mid_in_release", rst_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", rst_out, 0);
    check("mid_done", done, 0);
    check("mid_err", err, 0);
    check("mid_busy", busy, 1);
    sb.delete();
    mode = 0;
    df = 2;
    dr = 2;
    repeat (4) @(posedge clk);
    push_exp(1, 0, HOLD + 1, 2 + NS + 1);
    #1 rst_n = 1'b1;
    wait_idle(200);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("total_starts", starts, exp_starts);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
